// File: rtl/vram_text_writer_if.sv
// Request and VRAM-port signal bundle for vram_text_writer.
// The keyboard side drives data_in/ascii; everything else is produced by the writer.
interface vram_text_writer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) ();
    logic              data_in;
    logic [DATA_W-1:0] ascii;
    logic              wea;
    logic [ADDR_W-1:0] VAddr;
    logic [DATA_W-1:0] VData;
    logic              done;
    logic [ADDR_W-1:0] cursor;
    logic              err;

    modport master (
        output data_in, ascii,
        input  wea, VAddr, VData, done, cursor, err
    );

    modport slave (
        input  data_in, ascii,
        output wea, VAddr, VData, done, cursor, err
    );
endinterface

// File: rtl/vram_text_writer.sv
// Text-entry engine: turns ASCII requests into 3-phase VRAM writes inside a
// rectangular window, tracking a cursor with row/col counters. Falling-edge clocked.
module vram_text_writer #(
    parameter int              ADDR_W    = 11,
    parameter int              DATA_W    = 8,
    parameter int              BASE_ADDR = 120,
    parameter int              COLS      = 40,
    parameter int              LINES     = 8,
    parameter logic [DATA_W-1:0] FILL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    vram_text_writer_if.slave bus
);

    localparam int N     = COLS * LINES;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = $clog2(LINES + 1);
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_FULL = ROW_W'(LINES);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [K_W-1:0]    K_LAST   = K_W'(N - 1);
    localparam logic [K_W-1:0]    K_ONE    = K_W'(1);

    localparam logic [DATA_W-1:0] CH_BS    = DATA_W'(8'h08);
    localparam logic [DATA_W-1:0] CH_FF    = DATA_W'(8'h0C);
    localparam logic [DATA_W-1:0] CH_CR    = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] CH_SP    = DATA_W'(8'h20);
    localparam logic [DATA_W-1:0] CH_TILDE = DATA_W'(8'h7E);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_FIN
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PRINT,
        OP_BS,
        OP_CR,
        OP_CLR
    } op_t;

    state_t            state_q, state_n;
    op_t               op_q, op_n;
    logic [K_W-1:0]    k_q, k_n;
    logic [ADDR_W-1:0] vaddr_q, vaddr_n;
    logic [DATA_W-1:0] vdata_q, vdata_n;
    logic [ADDR_W-1:0] cursor_q, cursor_n;
    logic [COL_W-1:0]  col_q, col_n;
    logic [ROW_W-1:0]  row_q, row_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic              wea_q, wea_n;

    logic full;
    logic printable;

    // The window is full exactly when the row counter has stepped past the last line.
    assign full      = (row_q == ROW_FULL);
    assign printable = (bus.ascii >= CH_SP) && (bus.ascii <= CH_TILDE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_n  = state_q;
        op_n     = op_q;
        k_n      = k_q;
        vaddr_n  = vaddr_q;
        vdata_n  = vdata_q;
        cursor_n = cursor_q;
        col_n    = col_q;
        row_n    = row_q;
        done_n   = done_q;
        err_n    = 1'b0;
        wea_n    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.data_in) begin
                    done_n = 1'b0;
                    if (printable) begin
                        if (!full) begin
                            vaddr_n = cursor_q;
                            vdata_n = bus.ascii;
                            op_n    = OP_PRINT;
                            state_n = S_SETUP;
                        end else begin
                            err_n   = 1'b1;
                            op_n    = OP_NONE;
                            state_n = S_FIN;
                        end
                    end else if (bus.ascii == CH_BS) begin
                        if (cursor_q != BASE) begin
                            vaddr_n = cursor_q - ADDR_ONE;
                            vdata_n = FILL;
                            op_n    = OP_BS;
                            state_n = S_SETUP;
                        end else begin
                            op_n    = OP_NONE;
                            state_n = S_FIN;
                        end
                    end else if (bus.ascii == CH_CR) begin
                        op_n    = OP_CR;
                        state_n = S_FIN;
                    end else if (bus.ascii == CH_FF) begin
                        k_n     = '0;
                        vaddr_n = BASE;
                        vdata_n = FILL;
                        op_n    = OP_CLR;
                        state_n = S_SETUP;
                    end else begin
                        op_n    = OP_NONE;
                        state_n = S_FIN;
                    end
                end
            end

            // wea is registered, so it is requested one state ahead of STROBE.
            S_SETUP: begin
                wea_n   = 1'b1;
                state_n = S_STROBE;
            end

            S_STROBE: begin
                state_n = S_HOLD;
            end

            S_HOLD: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
                case (op_q)
                    OP_PRINT: begin
                        cursor_n = cursor_q + ADDR_ONE;
                        if (col_q == COL_LAST) begin
                            col_n = '0;
                            row_n = row_q + ROW_ONE;
                        end else begin
                            col_n = col_q + COL_ONE;
                        end
                    end
                    OP_BS: begin
                        cursor_n = cursor_q - ADDR_ONE;
                        if (col_q == '0) begin
                            col_n = COL_LAST;
                            row_n = row_q - ROW_ONE;
                        end else begin
                            col_n = col_q - COL_ONE;
                        end
                    end
                    OP_CLR: begin
                        if (k_q != K_LAST) begin
                            k_n     = k_q + K_ONE;
                            vaddr_n = vaddr_q + ADDR_ONE;
                            state_n = S_SETUP;
                            done_n  = 1'b0;
                        end else begin
                            cursor_n = BASE;
                            col_n    = '0;
                            row_n    = '0;
                        end
                    end
                    default: ;
                endcase
            end

            S_FIN: begin
                // Carriage return jumps by the cells left on this line; a full window stays put.
                if (op_q == OP_CR && !full) begin
                    cursor_n = cursor_q + COLS_A - ADDR_W'(col_q);
                    row_n    = row_q + ROW_ONE;
                    col_n    = '0;
                end
                done_n  = 1'b1;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NONE;
            k_q      <= '0;
            vaddr_q  <= BASE;
            vdata_q  <= '0;
            cursor_q <= BASE;
            col_q    <= '0;
            row_q    <= '0;
            done_q   <= 1'b1;
            err_q    <= 1'b0;
            wea_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_n;
            op_q     <= op_n;
            k_q      <= k_n;
            vaddr_q  <= vaddr_n;
            vdata_q  <= vdata_n;
            cursor_q <= cursor_n;
            col_q    <= col_n;
            row_q    <= row_n;
            done_q   <= done_n;
            err_q    <= err_n;
            wea_q    <= wea_n;
        end
    end

    assign bus.wea    = wea_q;
    assign bus.VAddr  = vaddr_q;
    assign bus.VData  = vdata_q;
    assign bus.done   = done_q;
    assign bus.cursor = cursor_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_vram_text_writer.sv
// Directed bench for vram_text_writer; the DUT updates on falling edges, so the
// bench drives and samples on rising edges.
module tb_vram_text_writer;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    logic clk = 1'b1;
    logic rst = 1'b0;

    vram_text_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_text_writer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(120),
        .COLS(40), .LINES(8), .FILL(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int wr_addr[$];
    int wr_data[$];
    int err_pulses = 0;
    int range_viol = 0;

    // Write/error log, sampled mid-cycle.
    always @(posedge clk) begin
        if (bus.wea === 1'b1) begin
            wr_addr.push_back(int'(bus.VAddr));
            wr_data.push_back(int'(bus.VData));
            if (bus.VAddr < 11'd120 || bus.VAddr > 11'd439) range_viol++;
        end
        if (bus.err === 1'b1) err_pulses++;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        err_pulses = 0;
    endtask

    task automatic apply_reset();
        bus.data_in = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        rst = 1'b1;
    endtask

    // Pulse one request; edges counts falling edges from acceptance until done=1.
    task automatic do_req(input logic [7:0] code, output int edges);
        @(posedge clk);
        bus.data_in = 1'b1;
        bus.ascii   = code;
        @(posedge clk);
        bus.data_in = 1'b0;
        edges = 1;
        while (bus.done !== 1'b1 && edges < 2000) begin
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL reset_done: got %b expected 1", bus.done); end
        checks++; if (bus.wea !== 1'b0) begin errors++; $display("FAIL reset_wea: got %b expected 0", bus.wea); end
        checks++; if (bus.VAddr !== 11'd120) begin errors++; $display("FAIL reset_vaddr: got %0d expected 120", bus.VAddr); end
        checks++; if (bus.VData !== 8'h00) begin errors++; $display("FAIL reset_vdata: got %h expected 00", bus.VData); end
        checks++; if (bus.cursor !== 11'd120) begin errors++; $display("FAIL reset_cursor: got %0d expected 120", bus.cursor); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    endtask

    task automatic test_write();
        clear_log();
        @(posedge clk);
        bus.data_in = 1'b1;
        bus.ascii   = 8'h41;
        @(posedge clk);
        bus.data_in = 1'b0;
        checks++; if (bus.done !== 1'b0 || bus.wea !== 1'b0) begin errors++; $display("FAIL write_setup: got done=%b wea=%b expected done=0 wea=0", bus.done, bus.wea); end
        @(posedge clk);
        checks++; if (bus.wea !== 1'b1 || bus.VAddr !== 11'd120 || bus.VData !== 8'h41) begin errors++; $display("FAIL write_strobe: got wea=%b addr=%0d data=%h expected wea=1 addr=120 data=41", bus.wea, bus.VAddr, bus.VData); end
        @(posedge clk);
        checks++; if (bus.wea !== 1'b0 || bus.done !== 1'b0 || bus.VAddr !== 11'd120) begin errors++; $display("FAIL write_hold: got wea=%b done=%b addr=%0d expected wea=0 done=0 addr=120", bus.wea, bus.done, bus.VAddr); end
        @(posedge clk);
        checks++; if (bus.done !== 1'b1 || bus.cursor !== 11'd121) begin errors++; $display("FAIL write_done: got done=%b cursor=%0d expected done=1 cursor=121", bus.done, bus.cursor); end
        checks++; if (wr_addr.size() !== 1) begin errors++; $display("FAIL write_count: got %0d expected 1", wr_addr.size()); end
    endtask

    task automatic test_backspace();
        int e;
        apply_reset();
        clear_log();
        do_req(8'h08, e);
        checks++; if (e !== 2 || wr_addr.size() !== 0 || bus.cursor !== 11'd120) begin errors++; $display("FAIL bs_at_base: got edges=%0d writes=%0d cursor=%0d expected 2 0 120", e, wr_addr.size(), bus.cursor); end
        do_req(8'h41, e);
        do_req(8'h42, e);
        checks++; if (bus.cursor !== 11'd122) begin errors++; $display("FAIL bs_ab_cursor: got %0d expected 122", bus.cursor); end
        clear_log();
        do_req(8'h08, e);
        checks++; if (e !== 4 || wr_addr.size() !== 1) begin errors++; $display("FAIL bs_erase: got edges=%0d writes=%0d expected 4 1", e, wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 121 || wr_data[0] !== 0) begin errors++; $display("FAIL bs_erase_cell: got addr=%0d data=%0d expected 121 0", wr_addr[0], wr_data[0]); end
        end
        checks++; if (bus.cursor !== 11'd121) begin errors++; $display("FAIL bs_cursor: got %0d expected 121", bus.cursor); end
    endtask

    task automatic test_cr_full();
        int e;
        apply_reset();
        do_req(8'h78, e);
        do_req(8'h79, e);
        do_req(8'h7A, e);
        do_req(8'h0D, e);
        checks++; if (e !== 2 || bus.cursor !== 11'd160) begin errors++; $display("FAIL cr_line1: got edges=%0d cursor=%0d expected 2 160", e, bus.cursor); end
        for (int i = 0; i < 6; i++) do_req(8'h0D, e);
        checks++; if (bus.cursor !== 11'd400) begin errors++; $display("FAIL cr_row7: got %0d expected 400", bus.cursor); end
        do_req(8'h0D, e);
        checks++; if (bus.cursor !== 11'd440) begin errors++; $display("FAIL cr_full: got %0d expected 440", bus.cursor); end
        do_req(8'h0D, e);
        checks++; if (bus.cursor !== 11'd440) begin errors++; $display("FAIL cr_when_full: got %0d expected 440", bus.cursor); end
        clear_log();
        do_req(8'h5A, e);
        @(posedge clk);
        checks++; if (err_pulses !== 1 || wr_addr.size() !== 0 || e !== 2) begin errors++; $display("FAIL overflow: got err_pulses=%0d writes=%0d edges=%0d expected 1 0 2", err_pulses, wr_addr.size(), e); end
        checks++; if (bus.cursor !== 11'd440 || bus.err !== 1'b0) begin errors++; $display("FAIL overflow_state: got cursor=%0d err=%b expected 440 0", bus.cursor, bus.err); end
    endtask

    task automatic test_fill();
        int e;
        int bad;
        apply_reset();
        clear_log();
        for (int i = 0; i < 320; i++) do_req(8'(65 + i % 26), e);
        checks++; if (bus.cursor !== 11'd440 || wr_addr.size() !== 320) begin errors++; $display("FAIL fill: got cursor=%0d writes=%0d expected 440 320", bus.cursor, wr_addr.size()); end
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 120 + i || wr_data[i] !== 65 + i % 26) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL fill_cells: got %0d bad cells expected 0", bad); end
        clear_log();
        do_req(8'h08, e);
        checks++; if (wr_addr.size() !== 1 || bus.cursor !== 11'd439) begin errors++; $display("FAIL fill_bs: got writes=%0d cursor=%0d expected 1 439", wr_addr.size(), bus.cursor); end
        else begin
            checks++; if (wr_addr[0] !== 439 || wr_data[0] !== 0) begin errors++; $display("FAIL fill_bs_cell: got addr=%0d data=%0d expected 439 0", wr_addr[0], wr_data[0]); end
        end
    endtask

    task automatic test_bs_wrap();
        int e;
        apply_reset();
        do_req(8'h0D, e);
        clear_log();
        do_req(8'h08, e);
        checks++; if (bus.cursor !== 11'd159) begin errors++; $display("FAIL wrap_bs: got %0d expected 159", bus.cursor); end
        do_req(8'h43, e);
        checks++; if (bus.cursor !== 11'd160 || wr_addr.size() !== 2) begin errors++; $display("FAIL wrap_retype: got cursor=%0d writes=%0d expected 160 2", bus.cursor, wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 159 || wr_addr[1] !== 159 || wr_data[1] !== 67) begin errors++; $display("FAIL wrap_cells: got %0d %0d data %0d expected 159 159 67", wr_addr[0], wr_addr[1], wr_data[1]); end
        end
        do_req(8'h0D, e);
        checks++; if (bus.cursor !== 11'd200) begin errors++; $display("FAIL wrap_row: got %0d expected 200", bus.cursor); end
    endtask

    task automatic test_clear();
        int e;
        int bad;
        clear_log();
        do_req(8'h0C, e);
        checks++; if (e !== 961 || wr_addr.size() !== 320) begin errors++; $display("FAIL clear: got edges=%0d writes=%0d expected 961 320", e, wr_addr.size()); end
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 120 + i || wr_data[i] !== 0) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL clear_cells: got %0d bad cells expected 0", bad); end
        checks++; if (bus.cursor !== 11'd120) begin errors++; $display("FAIL clear_cursor: got %0d expected 120", bus.cursor); end
        do_req(8'h0D, e);
        checks++; if (bus.cursor !== 11'd160) begin errors++; $display("FAIL clear_rowcol: got %0d expected 160", bus.cursor); end
    endtask

    task automatic test_reset_mid();
        int e;
        do_req(8'h41, e);
        @(posedge clk);
        bus.data_in = 1'b1;
        bus.ascii   = 8'h41;
        @(posedge clk);
        bus.data_in = 1'b0;
        @(posedge clk);
        checks++; if (bus.wea !== 1'b1) begin errors++; $display("FAIL mid_strobe: got wea=%b expected 1", bus.wea); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.wea !== 1'b0 || bus.done !== 1'b1 || bus.cursor !== 11'd120 || bus.VAddr !== 11'd120) begin errors++; $display("FAIL mid_reset: got wea=%b done=%b cursor=%0d addr=%0d expected 0 1 120 120", bus.wea, bus.done, bus.cursor, bus.VAddr); end
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        checks++; if (bus.wea !== 1'b0 || bus.done !== 1'b1) begin errors++; $display("FAIL mid_after: got wea=%b done=%b expected 0 1", bus.wea, bus.done); end
    endtask

    task automatic test_busy_ignore();
        int e;
        apply_reset();
        clear_log();
        @(posedge clk);
        bus.data_in = 1'b1;
        bus.ascii   = 8'h41;
        @(posedge clk);
        bus.data_in = 1'b0;
        @(posedge clk);
        bus.data_in = 1'b1;
        bus.ascii   = 8'h42;
        @(posedge clk);
        bus.data_in = 1'b0;
        e = 0;
        while (bus.done !== 1'b1 && e < 20) begin
            @(posedge clk);
            e++;
        end
        repeat (6) @(posedge clk);
        checks++; if (wr_addr.size() !== 1 || bus.cursor !== 11'd121) begin errors++; $display("FAIL busy_ignore: got writes=%0d cursor=%0d expected 1 121", wr_addr.size(), bus.cursor); end
        checks++; if (range_viol !== 0) begin errors++; $display("FAIL wea_range: got %0d out-of-window writes expected 0", range_viol); end
    endtask

    initial begin
        bus.data_in = 1'b0;
        bus.ascii   = 8'h00;
        test_reset();
        test_write();
        test_backspace();
        test_cr_full();
        test_fill();
        test_bs_wrap();
        test_clear();
        test_reset_mid();
        test_busy_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
